// File: rtl/sha256_msg_sched_ctrl.sv
// sha256_msg_sched_ctrl: sequencer that loads a 512-bit block into the SHA-256 message scheduler and steps rounds 0..63
//   clk, reset_n (async, active-low)
//   start_i, abort_i                        : block request / synchronous abort
//   msg_valid_i, msg_data_i, msg_ready_o    : 32-bit message word stream, M[0] first
//   ms_new_block_o, ms_ctrl_start_o, ms_stn_o, ms_we_o, ms_addr_o, ms_data_o, round_o : scheduler controls
//   wt_valid_o, cmp_ready_i                 : W[round_o] handshake towards the compression core
//   busy_o, done_o                          : status
module sha256_msg_sched_ctrl #(
  parameter int WCALC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        msg_valid_i,
  input  logic [31:0] msg_data_i,
  output logic        msg_ready_o,
  output logic        ms_new_block_o,
  output logic        ms_ctrl_start_o,
  output logic        ms_stn_o,
  output logic        ms_we_o,
  output logic [3:0]  ms_addr_o,
  output logic [31:0] ms_data_o,
  output logic [5:0]  round_o,
  output logic        wt_valid_o,
  input  logic        cmp_ready_i,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_HOLD} state_t;
  localparam logic [3:0] WLAST = 4'(WCALC_CYCLES - 1);
  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  logic [5:0]  r_round, w_round;
  logic [3:0]  r_wcnt, w_wcnt;
  logic        r_new_block, w_new_block;
  logic        r_done, w_done;
  logic        w_hi_round;
  assign w_hi_round      = r_round >= 6'd16;
  assign msg_ready_o     = r_state == S_LOAD;
  assign ms_we_o         = msg_valid_i & msg_ready_o;
  assign ms_addr_o       = r_cnt;
  // data is gated so every output reads 0 outside LOAD, including during reset
  assign ms_data_o       = msg_ready_o ? msg_data_i : 32'd0;
  assign ms_new_block_o  = r_new_block;
  assign ms_ctrl_start_o = r_state == S_ISSUE && r_round == 6'd0;
  assign ms_stn_o        = r_state == S_ISSUE && w_hi_round;
  assign round_o         = r_round;
  assign wt_valid_o      = r_state == S_HOLD;
  assign busy_o          = r_state != S_IDLE;
  assign done_o          = r_done;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_round     <= 6'd0;
      r_wcnt      <= 4'd0;
      r_new_block <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_round     <= w_round;
      r_wcnt      <= w_wcnt;
      r_new_block <= w_new_block;
      r_done      <= w_done;
    end
  end
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_round     = r_round;
    w_wcnt      = r_wcnt;
    w_new_block = 1'b0;
    w_done      = 1'b0;
    if (abort_i) begin
      w_state = S_IDLE;
      w_cnt   = 4'd0;
      w_round = 6'd0;
      w_wcnt  = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt   = 4'd0;
          w_round = 6'd0;
          if (start_i) begin
            w_state     = S_LOAD;
            w_new_block = 1'b1;
          end
        end
        S_LOAD: begin
          // counter wraps to 0 on the 16th word, leaving it clean for the next block
          if (ms_we_o) begin
            w_cnt   = r_cnt + 4'd1;
            w_state = r_cnt == 4'd15 ? S_ISSUE : S_LOAD;
          end
        end
        S_ISSUE: begin
          w_wcnt  = 4'd0;
          w_state = w_hi_round ? S_WAIT : S_HOLD;
        end
        S_WAIT: begin
          w_wcnt  = r_wcnt + 4'd1;
          w_state = r_wcnt == WLAST ? S_HOLD : S_WAIT;
        end
        S_HOLD: begin
          if (cmp_ready_i) begin
            if (r_round == 6'd63) begin
              w_state = S_IDLE;
              w_done  = 1'b1;
            end else begin
              w_round = r_round + 6'd1;
              w_state = S_ISSUE;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// tb_sha256_msg_sched_ctrl: randomized scoreboard bench with a behavioural message-schedule stub
module tb_sha256_msg_sched_ctrl;
  localparam int W = 4;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i, abort_i, msg_valid_i, cmp_ready_i;
  logic [31:0] msg_data_i;
  logic        msg_ready_o, ms_new_block_o, ms_ctrl_start_o, ms_stn_o, ms_we_o;
  logic [3:0]  ms_addr_o;
  logic [31:0] ms_data_o;
  logic [5:0]  round_o;
  logic        wt_valid_o, busy_o, done_o;

  sha256_msg_sched_ctrl #(.WCALC_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
    .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_ready_o(msg_ready_o),
    .ms_new_block_o(ms_new_block_o), .ms_ctrl_start_o(ms_ctrl_start_o), .ms_stn_o(ms_stn_o),
    .ms_we_o(ms_we_o), .ms_addr_o(ms_addr_o), .ms_data_o(ms_data_o), .round_o(round_o),
    .wt_valid_o(wt_valid_o), .cmp_ready_i(cmp_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [5:0] r; logic [31:0] w;} rexp_t;
  logic [35:0] wq[$];
  rexp_t       rq[$];
  int          dq[$];
  int          sq[$];
  int          checks = 0, errors = 0;
  int          cmp_mode = 1;
  bit          force0 = 0;
  logic [31:0] abc[16], rnd[16], obs[64], smem[64];

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void expand(input logic [31:0] m[16], output logic [31:0] w[64]);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    end
  endfunction

  function automatic logic [63:0] outs();
    return {msg_ready_o, ms_new_block_o, ms_ctrl_start_o, ms_stn_o, ms_we_o, ms_addr_o,
            ms_data_o, round_o, wt_valid_o, busy_o, done_o};
  endfunction

  initial begin
    cmp_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cmp_ready_i = force0 ? 1'b0 : cmp_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  int    cyc = 0, stn_cyc = 0, stn_rnd = 0, first_we = 0, last_we = 0, issue0 = 0, hs_cnt = 0, mr, span, lat;
  logic  prev_v = 1'b0;
  logic [35:0] we_e;
  rexp_t r_e;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (ms_new_block_o) begin
        for (int i = 0; i < 64; i++) begin
          smem[i] = 32'd0;
          obs[i]  = 32'd0;
        end
        hs_cnt = 0;
        chk("new_block_in_load", {63'd0, msg_ready_o}, 64'd1);
      end
      if (ms_we_o) begin
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          we_e = wq.pop_front();
          chk("write_addr_data", {28'd0, ms_addr_o, ms_data_o}, {28'd0, we_e});
        end
        if (ms_addr_o == 4'd0) first_we = cyc;
        last_we = cyc;
        smem[ms_addr_o] = ms_data_o;
      end
      if (ms_ctrl_start_o) begin
        issue0 = cyc;
        chk("ctrl_start_after_load", {26'd0, round_o, 32'(cyc - last_we)}, 64'd1);
        if (sq.size() != 0) begin
          span = sq.pop_front();
          if (span >= 0) chk("load_span", 64'(last_we - first_we), 64'(span));
        end
      end
      if (ms_stn_o) begin
        mr = int'(round_o);
        if (mr < 16) chk("stn_round_low", 64'(mr), 64'd16);
        else smem[mr] = s1(smem[mr-2]) + smem[mr-7] + s0(smem[mr-15]) + smem[mr-16];
        stn_cyc = cyc;
        stn_rnd = mr;
      end
      if (wt_valid_o && !prev_v && round_o >= 6'd16)
        chk("wt_valid_latency", {32'(stn_rnd), 32'(cyc - stn_cyc)}, {32'(round_o), 32'(W + 1)});
      if (wt_valid_o && cmp_ready_i) begin
        hs_cnt++;
        obs[round_o] = smem[round_o];
        if (rq.size() == 0) fail("unexpected_round");
        else begin
          r_e = rq.pop_front();
          chk("round_w", {26'd0, round_o, smem[round_o]}, {26'd0, r_e});
        end
      end
      if (done_o) begin
        if (dq.size() == 0) fail("unexpected_done");
        else begin
          lat = dq.pop_front();
          chk("done_rounds", 64'(hs_cnt), 64'd64);
          if (lat >= 0) chk("done_latency", 64'(cyc - issue0), 64'(lat));
        end
      end
      prev_v = wt_valid_o;
    end
  end

  // act: 0 none, 1 abort at round 30 WAIT, 2 start at round 40, 3 reset at round 50 HOLD, 4 cmp stall at round 20
  task automatic run_block(input logic [31:0] blk[16], input int gap, input int cmode, input int act,
                           input bit early, input bit sil, input int dlat);
    logic [31:0] wexp[64];
    int idx, budget;
    bit ph, v, acted;
    cmp_mode = cmode;
    expand(blk, wexp);
    for (int i = 0; i < 16; i++) wq.push_back({4'(i), blk[i]});
    for (int t = 0; t < 64; t++) rq.push_back('{r: 6'(t), w: wexp[t]});
    dq.push_back(dlat);
    sq.push_back(gap == 0 ? 15 : gap == 1 ? 30 : -1);
    if (!early) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    idx = 0;
    ph = 1'b0;
    budget = 200;
    while (idx < 16 && budget > 0) begin
      v = gap == 0 ? 1'b1 : gap == 1 ? !ph : 1'($urandom_range(0, 1));
      ph = !ph;
      msg_valid_i = v;
      msg_data_i = v ? blk[idx] : $urandom;
      start_i = sil && idx == 5;
      @(negedge clk);
      if (msg_valid_i && msg_ready_o) idx++;
      budget--;
      @(posedge clk);
      #1;
    end
    msg_valid_i = 1'b0;
    start_i = 1'b0;
    chk("load_words", 64'(idx), 64'd16);
    acted = 1'b0;
    for (budget = 4000; budget > 0; budget--) begin
      @(negedge clk);
      if (done_o) return;
      if (!acted && act == 1 && busy_o && !wt_valid_o && !ms_stn_o && !msg_ready_o && round_o == 6'd30) begin
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        rq.delete();
        dq.delete();
        @(negedge clk);
        chk("abort_idle", {busy_o, round_o, done_o, ms_stn_o, ms_ctrl_start_o, ms_new_block_o, wt_valid_o, msg_ready_o}, 64'd0);
        repeat (5) @(negedge clk);
        return;
      end
      if (!acted && act == 2 && round_o == 6'd40) begin
        acted = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
      if (!acted && act == 3 && wt_valid_o && round_o == 6'd50) begin
        #2 reset_n = 1'b0;
        #1;
        chk("reset_mid_outputs", outs(), 64'd0);
        wq.delete();
        rq.delete();
        dq.delete();
        sq.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        return;
      end
      if (!acted && act == 4 && ms_stn_o && round_o == 6'd20) begin
        acted = 1'b1;
        force0 = 1'b1;
        for (int k = 0; k < 20 && !wt_valid_o; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          chk("stall_round20", {57'd0, wt_valid_o, round_o}, {57'd0, 1'b1, 6'd20});
          if (k < 9) @(negedge clk);
        end
        force0 = 1'b0;
      end
    end
    fail("block_done");
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog bound expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) abc[i] = 32'd0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    reset_n = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    msg_valid_i = 1'b0;
    msg_data_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_outputs", outs(), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_idle_outputs", outs(), 64'd0);

    run_block(abc, 0, 1, 0, 1'b0, 1'b0, 320);
    chk("abc_w16", {32'd0, obs[16]}, {32'd0, 32'h61626380});
    chk("abc_w63", {32'd0, obs[63]}, {32'd0, 32'h12B1EDEB});
    run_block(abc, 1, 0, 4, 1'b1, 1'b0, -1);
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    run_block(rnd, 2, 0, 1, 1'b0, 1'b0, -1);
    run_block(abc, 0, 1, 0, 1'b0, 1'b0, 320);
    chk("abc_after_abort_w16", {32'd0, obs[16]}, {32'd0, 32'h61626380});
    chk("abc_after_abort_w63", {32'd0, obs[63]}, {32'd0, 32'h12B1EDEB});
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    run_block(rnd, 0, 0, 2, 1'b0, 1'b1, -1);
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    run_block(rnd, 2, 0, 3, 1'b0, 1'b0, -1);
    for (int i = 0; i < 16; i++) rnd[i] = $urandom;
    run_block(rnd, 2, 0, 0, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("final_idle", {62'd0, busy_o, done_o}, 64'd0);
    chk("queues_drained", 64'(wq.size() + rq.size() + dq.size() + sq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_msg_sched_ctrl.md
Name: sha256_msg_sched_ctrl

Overview:
- Sequencer in front of the SHA-256 message scheduler.
- Accepts one 512-bit block as 16 streamed 32-bit words and writes them into the scheduler's load port.
- Steps round_t from 0 to 63. For t>=16 it issues the compute trigger and waits out the scheduler's multi-cycle W[t] calculation.
- Presents each W[t] to the compression core with a valid/ready handshake and pulses done after round 63.

Parameters:
- WCALC_CYCLES, 4: clock cycles from the trigger cycle until the scheduler's W[t] output is final (t>=16 only); legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle request to process a new block; honoured only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE from any state
- msg_valid_i  in  1  message word valid
- msg_data_i  in  32  message word, M[0] first
- msg_ready_o  out  1  controller accepts a word this cycle
- ms_new_block_o  out  1  one-cycle pulse to scheduler start_new_block
- ms_ctrl_start_o  out  1  one-cycle pulse to scheduler CtrlStart at round 0
- ms_stn_o  out  1  one-cycle compute trigger for the current round (t>=16)
- ms_we_o  out  1  scheduler write_enable_in
- ms_addr_o  out  4  scheduler message_word_addr
- ms_data_o  out  32  scheduler message_word_in
- round_o  out  6  scheduler round_t
- wt_valid_o  out  1  scheduler Wt_out is valid for round_o
- cmp_ready_i  in  1  compression core consumes W[round_o]
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after round 63 is consumed

Behaviour:
- Reset: all outputs 0, round_o=0, word counter 0, state IDLE. Reset mid-operation discards the block; no done_o.
- States: IDLE, LOAD, ISSUE, WAIT, HOLD.
- IDLE:
  - start_i=1 -> LOAD next cycle, with ms_new_block_o=1 for exactly that first LOAD cycle.
  - Word counter cleared, round_o cleared to 0.
- LOAD:
  - msg_ready_o=1.
  - ms_we_o = msg_valid_i & msg_ready_o, combinational.
  - ms_addr_o = word counter; ms_data_o = msg_data_i, combinational pass-through.
  - Each handshake increments the counter.
  - The 16th handshake (addr 15) -> ISSUE with round_o=0. msg_ready_o is 0 from that cycle on.
  - Gaps in msg_valid_i stall the counter indefinitely.
- ISSUE (1 cycle):
  - round_o=0: ms_ctrl_start_o=1.
  - round_o>=16: ms_stn_o=1, then -> WAIT with the cycle counter cleared.
  - round_o<16: -> HOLD directly.
- WAIT:
  - Counter counts WCALC_CYCLES cycles, starting with the cycle after ISSUE.
  - After the last one -> HOLD, so wt_valid_o rises exactly WCALC_CYCLES+1 cycles after the ms_stn_o cycle.
- HOLD:
  - wt_valid_o=1; round_o held.
  - When cmp_ready_i=1:
    - round_o=63: done_o=1 next cycle and -> IDLE.
    - Otherwise round_o+1 and -> ISSUE.
  - cmp_ready_i is ignored outside HOLD.
- round_o changes only on the HOLD->ISSUE transition and on IDLE start. It is stable from ISSUE through the accepting HOLD cycle. It never wraps past 63.
- Minimum per-round latency:
  - t<16: 2 cycles (ISSUE+HOLD with cmp_ready_i=1).
  - t>=16: WCALC_CYCLES+2 cycles.
- abort_i (highest priority after reset):
  - Next cycle: IDLE, all pulses/strobes 0, round_o=0, no done_o.
  - Wins over a simultaneous start_i or cmp_ready_i.
- start_i while busy_o=1: ignored, no effect on any state.
- start_i in the same cycle done_o is high (state already IDLE): accepted normally.
- ms_we_o is never high outside LOAD. ms_stn_o/ms_ctrl_start_o are never high outside ISSUE.

Test Plan:
- Reset, then start_i with words 0x61626380, 0x0…0, 0x00000018 (abc block) streamed back-to-back -> ms_we_o high 16 consecutive cycles, addr 0..15. round_o=0 and ms_ctrl_start_o=1 on the cycle after the last write. Compression core observes W[16]=0x61626380, W[63]=0x12B1EDEB. done_o asserted once.
- cmp_ready_i tied 1, WCALC_CYCLES=4 -> rounds 0-15 take 2 cycles each, rounds 16-63 take 6 cycles each. done_o pulses 320 cycles after the first ISSUE cycle.
- msg_valid_i toggled 1/0 every cycle -> ms_addr_o still 0..15 in order; load takes 31 cycles. cmp_ready_i held 0 for 10 cycles at round 20 -> round_o stays 20 and wt_valid_o stays 1 throughout.
- abort_i at round 30 in WAIT -> next cycle busy_o=0, round_o=0, no done_o. A following start_i runs a full clean block with correct abc digest words.
- start_i pulsed during LOAD and during round 40 -> ignored; word count and round sequence unchanged. reset_n deasserted in HOLD at round 50 -> all outputs 0 immediately.
